// File: rtl/dram_pkg.sv
// Shared types and default timing for the DDR4 command/address bus checker.
// Command and error encodings are fixed here so that every consumer agrees on them.
package dram_pkg;

    localparam int unsigned ADDR_W_DEF = 14;
    localparam int unsigned T_RCD_DEF  = 10;
    localparam int unsigned T_RP_DEF   = 10;
    localparam int unsigned T_RAS_DEF  = 24;
    localparam int unsigned T_RFC_DEF  = 174;
    localparam int unsigned TW_DEF     = 8;

    localparam int unsigned NUM_BANKS  = 16;
    localparam int unsigned BANK_W     = 4;
    localparam int unsigned COL_W      = 10;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [3:0] {
        CMD_NONE = 4'd0,
        CMD_ACT  = 4'd1,
        CMD_RD   = 4'd2,
        CMD_WR   = 4'd3,
        CMD_PRE  = 4'd4,
        CMD_PREA = 4'd5,
        CMD_REF  = 4'd6,
        CMD_MRS  = 4'd7,
        CMD_ZQC  = 4'd8,
        CMD_RFU  = 4'd9
    } cmd_t;

    typedef enum logic [3:0] {
        ERR_NONE     = 4'd0,
        ERR_TRFC     = 4'd1,
        ERR_REF_OPEN = 4'd2,
        ERR_ACT_OPEN = 4'd3,
        ERR_TRP      = 4'd4,
        ERR_CLOSED   = 4'd5,
        ERR_TRCD     = 4'd6,
        ERR_TRAS     = 4'd7,
        ERR_RFU      = 4'd8
    } err_t;

    // Decode of a selected, clock-enabled bus slot; CMD_NONE stands for NOP.
    function automatic cmd_t decode_cmd(input logic act_n, input logic [2:0] rcw, input logic a10);
        cmd_t c;
        c = CMD_NONE;
        if (!act_n) begin
            c = CMD_ACT;
        end else begin
            case (rcw)
                3'b000:  c = CMD_MRS;
                3'b001:  c = CMD_REF;
                3'b010:  c = a10 ? CMD_PREA : CMD_PRE;
                3'b011:  c = CMD_RFU;
                3'b100:  c = CMD_WR;
                3'b101:  c = CMD_RD;
                3'b110:  c = CMD_ZQC;
                default: c = CMD_NONE;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/dram_bank_tracker.sv
// Per-bank open flag with saturating ACT and PRE timers.
// Each timer holds the elapsed count that the next sampled command will see.
module dram_bank_tracker
    import dram_pkg::*;
#(
    parameter int unsigned TW    = TW_DEF,
    parameter int unsigned T_RCD = T_RCD_DEF,
    parameter int unsigned T_RP  = T_RP_DEF,
    parameter int unsigned T_RAS = T_RAS_DEF
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_do_act,
    input  logic i_do_close,
    output logic o_open,
    output logic o_rcd_ok_c,
    output logic o_rp_ok_c,
    output logic o_ras_ok_c
);

    localparam logic [TW-1:0] T_MAX = '1;

    logic          r_open;
    logic [TW-1:0] r_t_act;
    logic [TW-1:0] r_t_pre;

    // A trigger loads 1 because the first command after it is one cycle later.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_open  <= 1'b0;
            r_t_act <= T_MAX;
            r_t_pre <= T_MAX;
        end else begin
            if (i_do_act) begin
                r_t_act <= TW'(1);
            end else if (r_t_act != T_MAX) begin
                r_t_act <= r_t_act + TW'(1);
            end

            if (i_do_close) begin
                r_t_pre <= TW'(1);
            end else if (r_t_pre != T_MAX) begin
                r_t_pre <= r_t_pre + TW'(1);
            end

            if (i_do_act) begin
                r_open <= 1'b1;
            end else if (i_do_close) begin
                r_open <= 1'b0;
            end
        end
    end

    assign o_open     = r_open;
    assign o_rcd_ok_c = (r_t_act >= TW'(T_RCD));
    assign o_rp_ok_c  = (r_t_pre >= TW'(T_RP));
    assign o_ras_ok_c = (r_t_act >= TW'(T_RAS));

endmodule

// File: rtl/dram_cmd_decoder.sv
// DDR4 command/address bus receiver: decodes each sampled slot, tracks bank state
// and refresh timing, and reports the highest-priority protocol violation.
module dram_cmd_decoder
    import dram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned T_RCD  = T_RCD_DEF,
    parameter int unsigned T_RP   = T_RP_DEF,
    parameter int unsigned T_RAS  = T_RAS_DEF,
    parameter int unsigned T_RFC  = T_RFC_DEF,
    parameter int unsigned TW     = TW_DEF
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  CKE,
    input  logic                  CS_n,
    input  logic                  ACT_n,
    input  logic                  RAS_n_A16,
    input  logic                  CAS_n_A15,
    input  logic                  WE_n_A14,
    input  logic [1:0]            BG,
    input  logic [1:0]            BA,
    input  logic [ADDR_W-1:0]     ADDR,
    output logic                  cmd_valid,
    output cmd_t                  cmd_type,
    output logic [BANK_W-1:0]     cmd_bank,
    output logic [ADDR_W+2:0]     cmd_row,
    output logic [COL_W-1:0]      cmd_col,
    output logic                  cmd_ap,
    output logic                  err_valid,
    output err_t                  err_code,
    output logic [NUM_BANKS-1:0]  bank_open,
    output logic [CNT_W-1:0]      rd_cnt,
    output logic [CNT_W-1:0]      wr_cnt
);

    localparam logic [TW-1:0] T_MAX = '1;

    logic [TW-1:0]        r_t_ref;

    cmd_t                 w_cmd;
    logic                 w_valid;
    logic [BANK_W-1:0]    w_bank;
    logic                 w_a10;
    logic                 w_is_rw;
    logic                 w_sel_open;
    logic                 w_ref_low;
    logic                 w_tras_bad;
    err_t                 w_err;
    logic [NUM_BANKS-1:0] w_do_act;
    logic [NUM_BANKS-1:0] w_do_close;
    logic [NUM_BANKS-1:0] w_open;
    logic [NUM_BANKS-1:0] w_rcd_ok;
    logic [NUM_BANKS-1:0] w_rp_ok;
    logic [NUM_BANKS-1:0] w_ras_ok;

    assign w_bank    = {BG, BA};
    assign w_a10     = ADDR[10];
    assign w_cmd     = (CKE && !CS_n) ? decode_cmd(ACT_n, {RAS_n_A16, CAS_n_A15, WE_n_A14}, w_a10)
                                      : CMD_NONE;
    assign w_valid   = (w_cmd != CMD_NONE);
    assign w_is_rw   = (w_cmd == CMD_RD) || (w_cmd == CMD_WR);
    assign w_ref_low = (r_t_ref < TW'(T_RFC));

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        dram_bank_tracker #(
            .TW    (TW),
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS)
        ) u_bank (
            .CLK        (CLK),
            .nRST       (nRST),
            .i_do_act   (w_do_act[g]),
            .i_do_close (w_do_close[g]),
            .o_open     (w_open[g]),
            .o_rcd_ok_c (w_rcd_ok[g]),
            .o_rp_ok_c  (w_rp_ok[g]),
            .o_ras_ok_c (w_ras_ok[g])
        );
    end

    // Bank strobes; closing only touches banks that are currently open.
    always_comb begin
        w_do_act   = '0;
        w_do_close = '0;
        w_sel_open = w_open[w_bank];
        case (w_cmd)
            CMD_ACT:        w_do_act[w_bank] = 1'b1;
            CMD_RD, CMD_WR: w_do_close[w_bank] = w_a10 && w_sel_open;
            CMD_PRE:        w_do_close[w_bank] = w_sel_open;
            CMD_PREA:       w_do_close = w_open;
            default:        w_do_close = '0;
        endcase
    end

    always_comb begin
        w_tras_bad = 1'b0;
        if (w_cmd == CMD_PRE) begin
            w_tras_bad = w_sel_open && !w_ras_ok[w_bank];
        end else if (w_cmd == CMD_PREA) begin
            w_tras_bad = |(w_open & ~w_ras_ok);
        end
    end

    // Violation priority mux, highest first.
    always_comb begin
        w_err = ERR_NONE;
        if (!w_valid) begin
            w_err = ERR_NONE;
        end else if (w_ref_low) begin
            w_err = ERR_TRFC;
        end else if ((w_cmd == CMD_REF) && (|w_open)) begin
            w_err = ERR_REF_OPEN;
        end else if ((w_cmd == CMD_ACT) && w_sel_open) begin
            w_err = ERR_ACT_OPEN;
        end else if ((w_cmd == CMD_ACT) && !w_rp_ok[w_bank]) begin
            w_err = ERR_TRP;
        end else if (w_is_rw && !w_sel_open) begin
            w_err = ERR_CLOSED;
        end else if (w_is_rw && !w_rcd_ok[w_bank]) begin
            w_err = ERR_TRCD;
        end else if (w_tras_bad) begin
            w_err = ERR_TRAS;
        end else if (w_cmd == CMD_RFU) begin
            w_err = ERR_RFU;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_t_ref <= T_MAX;
        end else if (w_cmd == CMD_REF) begin
            r_t_ref <= TW'(1);
        end else if (r_t_ref != T_MAX) begin
            r_t_ref <= r_t_ref + TW'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cmd_valid <= 1'b0;
            cmd_type  <= CMD_NONE;
            cmd_bank  <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            cmd_ap    <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
        end else begin
            cmd_valid <= w_valid;
            err_valid <= (w_err != ERR_NONE);
            if (w_valid) begin
                cmd_type <= w_cmd;
                cmd_bank <= w_bank;
                cmd_row  <= {RAS_n_A16, CAS_n_A15, WE_n_A14, ADDR};
                cmd_col  <= ADDR[COL_W-1:0];
                cmd_ap   <= w_is_rw && w_a10;
                err_code <= w_err;
            end
            if (w_cmd == CMD_RD) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
            if (w_cmd == CMD_WR) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

    assign bank_open = w_open;

endmodule

// File: tb/tb_dram_cmd_decoder.sv
// Directed and randomized checks of dram_cmd_decoder against a cycle-stamp reference model.
module tb_dram_cmd_decoder;
    import dram_pkg::*;

    localparam int TRCD = 10;
    localparam int TRP  = 10;
    localparam int TRAS = 24;
    localparam int TRFC = 174;
    localparam int TSAT = 255;
    localparam int NEVER = -100000;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        CKE = 1'b1;
    logic        CS_n = 1'b1;
    logic        ACT_n = 1'b1;
    logic        RAS_n_A16 = 1'b1;
    logic        CAS_n_A15 = 1'b1;
    logic        WE_n_A14 = 1'b1;
    logic [1:0]  BG = 2'd0;
    logic [1:0]  BA = 2'd0;
    logic [13:0] ADDR = 14'd0;

    logic        cmd_valid;
    cmd_t        cmd_type;
    logic [3:0]  cmd_bank;
    logic [16:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        cmd_ap;
    logic        err_valid;
    err_t        err_code;
    logic [15:0] bank_open;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    int total = 0;
    int bad   = 0;

    // Reference state: cycle stamps of the last trigger per bank and for refresh.
    int          cyc = 0;
    bit          m_open [16];
    int          m_act  [16];
    int          m_pre  [16];
    int          m_ref;
    logic [15:0] m_rd;
    logic [15:0] m_wr;

    dram_cmd_decoder dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .CKE       (CKE),
        .CS_n      (CS_n),
        .ACT_n     (ACT_n),
        .RAS_n_A16 (RAS_n_A16),
        .CAS_n_A15 (CAS_n_A15),
        .WE_n_A14  (WE_n_A14),
        .BG        (BG),
        .BA        (BA),
        .ADDR      (ADDR),
        .cmd_valid (cmd_valid),
        .cmd_type  (cmd_type),
        .cmd_bank  (cmd_bank),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .cmd_ap    (cmd_ap),
        .err_valid (err_valid),
        .err_code  (err_code),
        .bank_open (bank_open),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int tmr(input int last);
        int d;
        d = cyc - last;
        return (d > TSAT) ? TSAT : d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 1'b0;
            m_act[i]  = NEVER;
            m_pre[i]  = NEVER;
        end
        m_ref = NEVER;
        m_rd  = '0;
        m_wr  = '0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0; CKE = 1'b1; CS_n = 1'b1; ACT_n = 1'b1;
        RAS_n_A16 = 1'b1; CAS_n_A15 = 1'b1; WE_n_A14 = 1'b1;
        #1;
        model_reset();
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        chk("rst_cmd_type",  32'(cmd_type),  32'd0);
        chk("rst_err_code",  32'(err_code),  32'd0);
        chk("rst_bank_open", 32'(bank_open), 32'd0);
        chk("rst_rd_cnt",    32'(rd_cnt),    32'd0);
        chk("rst_wr_cnt",    32'(wr_cnt),    32'd0);
        @(posedge CLK);
        #1;
        cyc++;
        nRST = 1'b1;
    endtask

    // One bus slot: predict, drive on the falling edge, check after the rising edge.
    task automatic step(input bit cke, input bit cs, input bit actn, input bit ras, input bit cas,
                        input bit we, input logic [3:0] bank, input logic [13:0] addr);
        cmd_t        et;
        err_t        ee;
        bit          ev;
        bit          anyopen;
        bit          prea_bad;
        int          b;
        logic [15:0] eo;
        logic [2:0]  rcw;

        b   = int'(bank);
        et  = CMD_NONE;
        rcw = {ras, cas, we};
        if (cke && !cs) begin
            if (!actn) et = CMD_ACT;
            else begin
                case (rcw)
                    3'b000:  et = CMD_MRS;
                    3'b001:  et = CMD_REF;
                    3'b010:  et = addr[10] ? CMD_PREA : CMD_PRE;
                    3'b011:  et = CMD_RFU;
                    3'b100:  et = CMD_WR;
                    3'b101:  et = CMD_RD;
                    3'b110:  et = CMD_ZQC;
                    default: et = CMD_NONE;
                endcase
            end
        end
        ev = (et != CMD_NONE);

        anyopen  = 1'b0;
        prea_bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (m_open[i]) anyopen = 1'b1;
            if (m_open[i] && tmr(m_act[i]) < TRAS) prea_bad = 1'b1;
        end

        ee = ERR_NONE;
        if (ev) begin
            if (tmr(m_ref) < TRFC)                                        ee = ERR_TRFC;
            else if (et == CMD_REF && anyopen)                            ee = ERR_REF_OPEN;
            else if (et == CMD_ACT && m_open[b])                          ee = ERR_ACT_OPEN;
            else if (et == CMD_ACT && tmr(m_pre[b]) < TRP)                ee = ERR_TRP;
            else if ((et == CMD_RD || et == CMD_WR) && !m_open[b])        ee = ERR_CLOSED;
            else if ((et == CMD_RD || et == CMD_WR) && tmr(m_act[b]) < TRCD) ee = ERR_TRCD;
            else if ((et == CMD_PRE && m_open[b] && tmr(m_act[b]) < TRAS) ||
                     (et == CMD_PREA && prea_bad))                        ee = ERR_TRAS;
            else if (et == CMD_RFU)                                       ee = ERR_RFU;
        end

        case (et)
            CMD_ACT: begin m_open[b] = 1'b1; m_act[b] = cyc; end
            CMD_RD, CMD_WR: begin
                if (addr[10] && m_open[b]) begin m_open[b] = 1'b0; m_pre[b] = cyc; end
                if (et == CMD_RD) m_rd = m_rd + 16'd1;
                else              m_wr = m_wr + 16'd1;
            end
            CMD_PRE: if (m_open[b]) begin m_open[b] = 1'b0; m_pre[b] = cyc; end
            CMD_PREA: begin
                for (int i = 0; i < 16; i++) begin
                    if (m_open[i]) begin m_open[i] = 1'b0; m_pre[i] = cyc; end
                end
            end
            CMD_REF: m_ref = cyc;
            default: ;
        endcase
        for (int i = 0; i < 16; i++) eo[i] = m_open[i];

        @(negedge CLK);
        CKE = cke; CS_n = cs; ACT_n = actn;
        RAS_n_A16 = ras; CAS_n_A15 = cas; WE_n_A14 = we;
        BG = bank[3:2]; BA = bank[1:0]; ADDR = addr;
        @(posedge CLK);
        #1;
        cyc++;

        chk("cmd_valid", 32'(cmd_valid), 32'(ev));
        chk("err_valid", 32'(err_valid), 32'(ee != ERR_NONE));
        chk("bank_open", 32'(bank_open), 32'(eo));
        chk("rd_cnt",    32'(rd_cnt),    32'(m_rd));
        chk("wr_cnt",    32'(wr_cnt),    32'(m_wr));
        if (ev) begin
            chk("cmd_type", 32'(cmd_type), 32'(et));
            chk("cmd_bank", 32'(cmd_bank), 32'(bank));
            if (et == CMD_ACT) chk("cmd_row", 32'(cmd_row), 32'({ras, cas, we, addr}));
            if (et == CMD_RD || et == CMD_WR) begin
                chk("cmd_col", 32'(cmd_col), 32'(addr[9:0]));
                chk("cmd_ap",  32'(cmd_ap),  32'(addr[10]));
            end
        end
        if (ee != ERR_NONE) chk("err_code", 32'(err_code), 32'(ee));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 1, 1, 1, 1, 4'd0, 14'd0);
    endtask

    task automatic act(input logic [3:0] bank, input logic [16:0] row);
        step(1, 0, 0, row[16], row[15], row[14], bank, row[13:0]);
    endtask

    task automatic rd(input logic [3:0] bank, input logic [9:0] col, input bit ap);
        step(1, 0, 1, 1, 0, 1, bank, {3'b000, ap, col});
    endtask

    task automatic wr(input logic [3:0] bank, input logic [9:0] col, input bit ap);
        step(1, 0, 1, 1, 0, 0, bank, {3'b000, ap, col});
    endtask

    task automatic pre(input logic [3:0] bank);
        step(1, 0, 1, 0, 1, 0, bank, 14'd0);
    endtask

    task automatic prea();
        step(1, 0, 1, 0, 1, 0, 4'd0, 14'h0400);
    endtask

    task automatic refr();
        step(1, 0, 1, 0, 0, 1, 4'd0, 14'd0);
    endtask

    task automatic dir_err(input string tag, input err_t e);
        chk(tag, err_valid ? 32'(err_code) : 32'(ERR_NONE), 32'(e));
    endtask

    initial begin
        int          r;
        logic [3:0]  rb;
        logic [13:0] ra;

        model_reset();
        do_reset();
        idle(2);

        act(4'd5, 17'h0AAAA);
        idle(9);
        rd(4'd5, 10'h0A0, 1'b0);
        dir_err("rd_k10_clean", ERR_NONE);
        chk("open5", 32'(bank_open[5]), 32'd1);
        chk("rd_cnt1", 32'(rd_cnt), 32'd1);

        act(4'd0, 17'h00123);
        idle(8);
        wr(4'd0, 10'h011, 1'b0);
        dir_err("wr_k9_trcd", ERR_TRCD);
        wr(4'd0, 10'h012, 1'b0);
        dir_err("wr_k10_clean", ERR_NONE);
        chk("wr_cnt2", 32'(wr_cnt), 32'd2);

        act(4'd3, 17'h1F00F);
        idle(22);
        pre(4'd3);
        dir_err("pre_k23_tras", ERR_TRAS);
        chk("open3_closed", 32'(bank_open[3]), 32'd0);
        idle(8);
        act(4'd3, 17'h00001);
        dir_err("act_k9_trp", ERR_TRP);
        idle(30);
        pre(4'd3);
        dir_err("pre_late_clean", ERR_NONE);
        idle(9);
        act(4'd3, 17'h00002);
        dir_err("act_k10_clean", ERR_NONE);

        act(4'd2, 17'h00010);
        act(4'd7, 17'h00020);
        idle(3);
        refr();
        dir_err("ref_open", ERR_REF_OPEN);
        prea();
        idle(10);
        refr();
        idle(172);
        act(4'd8, 17'h00030);
        dir_err("act_k173_trfc", ERR_TRFC);
        act(4'd9, 17'h00040);
        dir_err("act_k174_clean", ERR_NONE);

        act(4'd4, 17'h00050);
        idle(10);
        rd(4'd4, 10'h3FF, 1'b1);
        chk("open4_ap", 32'(bank_open[4]), 32'd0);
        rd(4'd4, 10'h001, 1'b0);
        dir_err("rd_closed", ERR_CLOSED);

        step(0, 0, 0, 0, 0, 0, 4'd6, 14'd0);
        chk("cke0_no_cmd", 32'(cmd_valid), 32'd0);

        act(4'd10, 17'h00060);
        act(4'd11, 17'h00070);
        do_reset();
        act(4'd10, 17'h00080);
        dir_err("act_after_reset", ERR_NONE);

        for (int n = 0; n < 600; n++) begin
            r  = int'($urandom_range(0, 99));
            rb = 4'($urandom_range(0, 15));
            ra = 14'($urandom);
            if (r < 28)      idle(int'($urandom_range(1, 12)));
            else if (r < 48) act(rb, 17'($urandom));
            else if (r < 60) rd(rb, ra[9:0], ($urandom_range(0, 3) == 0));
            else if (r < 72) wr(rb, ra[9:0], ($urandom_range(0, 3) == 0));
            else if (r < 80) pre(rb);
            else if (r < 83) prea();
            else if (r < 85) refr();
            else if (r < 98) step(($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom),
                                  1'($urandom), 1'($urandom), 1'($urandom), rb, ra);
            else             do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
